// File: rtl/accum_seq_pkg.sv
// Shared definitions for the accumulation stage: state encodings and default widths.
package accum_seq_pkg;

    localparam int ACC_W_DEFAULT  = 6;
    localparam int DATA_W_DEFAULT = 4;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/accum_adder.sv
// Combinational W-bit adder with carry-in and carry-out, shaped like the team's full adder.
module accum_adder #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sum      = wide_sum[W-1:0];
        cout     = wide_sum[W];
    end

endmodule

// File: rtl/accum_seq.sv
// Burst accumulator: sums COUNT operands and presents the registered total with a sticky
// overflow flag on a valid/ready output.  Handshake: a beat moves on a rising edge where valid && ready.
module accum_seq
    import accum_seq_pkg::*;
#(
    parameter int WIDTH     = DATA_W_DEFAULT,
    parameter int ACC_WIDTH = ACC_W_DEFAULT,
    parameter int COUNT     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    if (ACC_WIDTH < WIDTH || COUNT < 1 || COUNT > 15) begin : g_param_check
        $error("accum_seq: illegal parameters ACC_WIDTH=%0d WIDTH=%0d COUNT=%0d",
               ACC_WIDTH, WIDTH, COUNT);
    end

    localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic                 accept;
    logic                 in_accum;
    logic [ACC_WIDTH-1:0] add_a;
    logic [ACC_WIDTH-1:0] add_b;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_cout;
    logic [CNT_W-1:0]     cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // A burst start adds the operand to zero, so IDLE and ACCUM share the one adder.
    always_comb begin
        in_accum = (state_q == ST_ACCUM);
        accept   = in_valid && in_ready;
        add_a    = in_accum ? acc_q : '0;
        add_b    = '0;
        add_b[WIDTH-1:0] = in_data;
        cnt_next = in_accum ? (cnt_q + 4'd1) : 4'd1;
    end

    accum_adder #(
        .W(ACC_WIDTH)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        state_d = (cnt_next == COUNT_C) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        acc_d = add_sum;
                        cnt_d = cnt_next;
                        ovf_d = (in_accum && ovf_q) || add_cout;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs depend on registered state only, so nothing from in_* reaches out_* in one cycle.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
        out_valid = (state_q == ST_HOLD);
        busy      = (state_q == ST_ACCUM) || (state_q == ST_HOLD);
        out_sum   = acc_q;
        out_ovf   = ovf_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_accum_seq.sv
// Bench for accum_seq: two instances (ACC_WIDTH 6 and 5) share one stimulus stream and one scoreboard.
module tb_accum_seq;

    localparam int W     = 4;
    localparam int COUNT = 4;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;
    logic       ready_force;
    logic       rand_ready;
    logic       rnd_ready;

    logic       in_ready, in_ready5;
    logic       out_valid, out_valid5;
    logic [5:0] out_sum;
    logic [4:0] out_sum5;
    logic       out_ovf, out_ovf5;
    logic       busy, busy5;
    logic [1:0] dbg_state, dbg_state5;

    int n_checks;
    int n_pass;

    logic [12:0] exp_q[$];
    int          burst_q[$];

    assign out_ready = rand_ready ? rnd_ready : ready_force;

    accum_seq #(.WIDTH(W), .ACC_WIDTH(6), .COUNT(COUNT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    accum_seq #(.WIDTH(W), .ACC_WIDTH(5), .COUNT(COUNT)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready5),
        .in_data   (in_data),
        .out_valid (out_valid5),
        .out_ready (out_ready),
        .out_sum   (out_sum5),
        .out_ovf   (out_ovf5),
        .busy      (busy5),
        .dbg_state (dbg_state5)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // reference model: a burst's result is just the plain sum of its operands
    task automatic model_accept(input int d);
        int total;
        burst_q.push_back(d);
        if (burst_q.size() == COUNT) begin
            total = 0;
            foreach (burst_q[i]) total += burst_q[i];
            exp_q.push_back({(total >= 64), 6'(total % 64), (total >= 32), 5'(total % 32)});
            burst_q.delete();
        end
    endtask

    // driver tasks
    task automatic send(input int d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = 4'(d);
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) begin
            chk("send_timeout", 1, 0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(d);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_burst(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
    endtask

    // random back-pressure source
    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid !== out_valid5) chk("valid_agree", {31'd0, out_valid5}, {31'd0, out_valid});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("result", {19'd0, out_ovf, out_sum, out_ovf5, out_sum5}, {19'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int t;
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        ready_force = 1'b1;
        rand_ready  = 1'b0;
        rnd_ready   = 1'b0;

        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_sum", {26'd0, out_sum}, 0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_state", {30'd0, dbg_state}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic burst with latency checks
        send(3); send(5); send(7);
        chk("basic_not_early", {31'd0, out_valid}, 0);
        send(9);
        chk("basic_latency", {31'd0, out_valid}, 1);
        chk("basic_in_ready_low", {31'd0, in_ready}, 0);
        chk("basic_hold_state", {30'd0, dbg_state}, 2);
        @(posedge clk); #1;
        chk("basic_back_idle", {31'd0, out_valid}, 0);
        chk("basic_busy_idle", {31'd0, busy}, 0);

        // overflow on the 5-bit instance, then a clean burst
        send_burst(15, 15, 15, 15);
        send_burst(1, 1, 1, 1);
        idle(2);

        // back-pressure
        ready_force = 1'b0;
        send_burst(2, 2, 2, 2);
        in_valid = 1'b1;
        in_data  = 4'd5;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 1);
            chk("bp_sum", {26'd0, out_sum}, 8);
            chk("bp_in_ready", {31'd0, in_ready}, 0);
            @(posedge clk); #1;
        end
        ready_force = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", {31'd0, out_valid}, 0);
        chk("bp_not_accepted", {31'd0, busy}, 0);
        send(5); send(1); send(1); send(1);

        // input gaps
        send(1);
        idle(2);
        chk("gap_busy", {31'd0, busy}, 1);
        chk("gap_no_valid", {31'd0, out_valid}, 0);
        send(2);
        idle(1);
        send(3);
        send(4);
        idle(2);

        // abort with an operand in the clear cycle
        send(6); send(6);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd9;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        burst_q.delete();
        chk("clear_busy", {31'd0, busy}, 0);
        chk("clear_valid", {31'd0, out_valid}, 0);
        chk("clear_sum", {26'd0, out_sum}, 0);
        chk("clear_ovf", {31'd0, out_ovf5}, 0);
        send_burst(1, 1, 1, 1);
        idle(2);

        // asynchronous reset while holding a result
        ready_force = 1'b0;
        send_burst(2, 3, 4, 5);
        chk("arst_pre_valid", {31'd0, out_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 0);
        chk("arst_sum", {26'd0, out_sum}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_in_ready", {31'd0, in_ready}, 1);
        exp_q.delete();
        burst_q.delete();
        ready_force = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // randomized bursts with random back-pressure and gaps
        rand_ready = 1'b1;
        for (int b = 0; b < 25; b++) begin
            for (int k = 0; k < COUNT; k++) begin
                send(int'($urandom_range(0, 15)));
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            end
        end
        rand_ready = 1'b0;

        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
